// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration loader and startup sequencer for the XC20xx fabric model.
// Optional per-frame even parity is enabled by defining XC20XX_CFG_PARITY_EN.
module xc20xx_cfg_loader #(
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STARTUP_CYC = 4
) (
  input  logic               K,
  input  logic               RN,
  input  logic               DIN,
  input  logic               DIN_EN,
  output logic [FRAME_W-1:0] FRAME_DATA,
  output logic [ADDR_W-1:0]  FRAME_ADDR,
  output logic               FRAME_VLD,
  output logic               GR,
  output logic               DONE,
  output logic               ERR
);

  localparam int unsigned LEN_W  = 24;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned SU_W   = $clog2(STARTUP_CYC + 1);
  localparam logic [7:0]  SYNC_WORD = 8'hF2;
  localparam logic [FRAME_W-1:0] MASK_MSB = {1'b1, {(FRAME_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_TRAIL,
    S_DATA,
    S_STARTUP,
    S_RUN,
    S_ERROR
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         hunt_sr, hunt_nxt;
  logic [LEN_W-1:0]   len_cnt, len_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt;
  logic [FRAME_W-1:0] frame_sr, frame_nxt;
  logic [FRAME_W-1:0] mask, mask_nxt;
  logic [SU_W-1:0]    su_cnt, su_nxt;
  logic [ADDR_W-1:0]  addr_cnt, addr_nxt;
  logic [FRAME_W-1:0] data_nxt;
  logic [ADDR_W-1:0]  faddr_nxt;
  logic               vld_nxt, gr_nxt, done_nxt, err_nxt;
  logic               emit_c, last_frame_c;
`ifdef XC20XX_CFG_PARITY_EN
  logic               par_acc, par_nxt;
  logic               par_pend, pend_nxt;
`endif

  // State and datapath registers; every output is a flop.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      state      <= S_HUNT;
      hunt_sr    <= '0;
      len_cnt    <= '0;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      mask       <= '0;
      su_cnt     <= '0;
      addr_cnt   <= '0;
      FRAME_DATA <= '0;
      FRAME_ADDR <= '0;
      FRAME_VLD  <= 1'b0;
      GR         <= 1'b1;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
`ifdef XC20XX_CFG_PARITY_EN
      par_acc    <= 1'b0;
      par_pend   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      hunt_sr    <= hunt_nxt;
      len_cnt    <= len_nxt;
      bit_cnt    <= bit_nxt;
      frame_sr   <= frame_nxt;
      mask       <= mask_nxt;
      su_cnt     <= su_nxt;
      addr_cnt   <= addr_nxt;
      FRAME_DATA <= data_nxt;
      FRAME_ADDR <= faddr_nxt;
      FRAME_VLD  <= vld_nxt;
      GR         <= gr_nxt;
      DONE       <= done_nxt;
      ERR        <= err_nxt;
`ifdef XC20XX_CFG_PARITY_EN
      par_acc    <= par_nxt;
      par_pend   <= pend_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    hunt_nxt     = hunt_sr;
    len_nxt      = len_cnt;
    bit_nxt      = bit_cnt;
    frame_nxt    = frame_sr;
    mask_nxt     = mask;
    su_nxt       = su_cnt;
    addr_nxt     = addr_cnt;
    data_nxt     = FRAME_DATA;
    faddr_nxt    = FRAME_ADDR;
    vld_nxt      = 1'b0;
    gr_nxt       = GR;
    done_nxt     = DONE;
    err_nxt      = ERR;
    emit_c       = 1'b0;
    last_frame_c = 1'b0;
`ifdef XC20XX_CFG_PARITY_EN
    par_nxt      = par_acc;
    pend_nxt     = par_pend;
`endif

    case (state)
      S_HUNT: begin
        if (DIN_EN) begin
          hunt_nxt = {hunt_sr[6:0], DIN};
          if (hunt_nxt == SYNC_WORD) begin
            state_nxt = S_LEN;
            bit_nxt   = '0;
          end
        end
      end

      S_LEN: begin
        if (DIN_EN) begin
          len_nxt = {len_cnt[LEN_W-2:0], DIN};
          if (bit_cnt == BIT_W'(LEN_W - 1)) begin
            state_nxt = S_TRAIL;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      S_TRAIL: begin
        if (DIN_EN) begin
          if (!DIN) begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end else if (bit_cnt == BIT_W'(3)) begin
            bit_nxt   = '0;
            frame_nxt = '0;
            mask_nxt  = MASK_MSB;
            if (len_cnt != '0) begin
              state_nxt = S_DATA;
            end else begin
              state_nxt = S_STARTUP;
              su_nxt    = SU_W'(STARTUP_CYC);
            end
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      // The one-hot mask marks the next bit position, so a short final
      // frame stays left-aligned with zeros below it.
      S_DATA: begin
        if (DIN_EN) begin
`ifdef XC20XX_CFG_PARITY_EN
          if (par_pend) begin
            pend_nxt = 1'b0;
            par_nxt  = 1'b0;
            if (par_acc != DIN) begin
              state_nxt = S_ERROR;
              err_nxt   = 1'b1;
            end else begin
              emit_c       = 1'b1;
              last_frame_c = (len_cnt == '0);
            end
          end else begin
            frame_nxt = DIN ? (frame_sr | mask) : frame_sr;
            mask_nxt  = mask >> 1;
            len_nxt   = len_cnt - LEN_W'(1);
            par_nxt   = par_acc ^ DIN;
            if (mask[0] || (len_cnt == LEN_W'(1))) begin
              pend_nxt = 1'b1;
            end
          end
`else
          frame_nxt = DIN ? (frame_sr | mask) : frame_sr;
          mask_nxt  = mask >> 1;
          len_nxt   = len_cnt - LEN_W'(1);
          if (mask[0] || (len_cnt == LEN_W'(1))) begin
            emit_c       = 1'b1;
            last_frame_c = (len_cnt == LEN_W'(1));
          end
`endif
        end
      end

      S_STARTUP: begin
        if (su_cnt <= SU_W'(1)) begin
          state_nxt = S_RUN;
          done_nxt  = 1'b1;
          su_nxt    = '0;
        end else begin
          su_nxt = su_cnt - SU_W'(1);
        end
      end

      S_RUN: begin
        gr_nxt = 1'b0;
      end

      S_ERROR: begin
        err_nxt  = 1'b1;
        gr_nxt   = 1'b1;
        done_nxt = 1'b0;
      end

      default: begin
        state_nxt = S_HUNT;
      end
    endcase

    // Frame hand-off to the configuration memory.
    if (emit_c) begin
      vld_nxt   = 1'b1;
      data_nxt  = frame_nxt;
      faddr_nxt = addr_cnt;
      addr_nxt  = addr_cnt + ADDR_W'(1);
      frame_nxt = '0;
      mask_nxt  = MASK_MSB;
      if (last_frame_c) begin
        state_nxt = S_STARTUP;
        su_nxt    = SU_W'(STARTUP_CYC);
      end
    end
  end

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Bench for xc20xx_cfg_loader: a stream-level model predicts every output per cycle.
// Honours XC20XX_CFG_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_xc20xx_cfg_loader;

  localparam int FW    = 16;
  localparam int AW    = 8;
  localparam int SC    = 4;
  localparam int MAXC  = 1024;
  localparam int NEVER = 1 << 30;

  logic          K = 1'b0;
  logic          RN = 1'b1;
  logic          DIN = 1'b0;
  logic          DIN_EN = 1'b0;
  logic [FW-1:0] FRAME_DATA;
  logic [AW-1:0] FRAME_ADDR;
  logic          FRAME_VLD, GR, DONE, ERR;

  xc20xx_cfg_loader #(.FRAME_W(FW), .ADDR_W(AW), .STARTUP_CYC(SC)) dut (
    .K(K), .RN(RN), .DIN(DIN), .DIN_EN(DIN_EN),
    .FRAME_DATA(FRAME_DATA), .FRAME_ADDR(FRAME_ADDR), .FRAME_VLD(FRAME_VLD),
    .GR(GR), .DONE(DONE), .ERR(ERR)
  );

  always #5 K = ~K;

  int n_err = 0;
  int n_checks = 0;

  // Stimulus per cycle and model expectations per cycle.
  logic    s_din [MAXC];
  logic    s_en  [MAXC];
  int      ncyc;
  int      en_mode;
  int      last_bit_cyc;
  logic          e_vld [MAXC];
  logic          e_done[MAXC];
  logic          e_gr  [MAXC];
  logic          e_err [MAXC];
  logic [FW-1:0] e_data[MAXC];
  logic [AW-1:0] e_addr[MAXC];

  // Observed DUT events, for literal pins.
  logic [FW-1:0] obs_d[$];
  logic [AW-1:0] obs_a[$];
  int            obs_done_c;
  int            obs_err_c;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  function automatic logic [31:0] obs_dat(input int idx);
    return (idx < obs_d.size()) ? 32'(obs_d[idx]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] obs_adr(input int idx);
    return (idx < obs_a.size()) ? 32'(obs_a[idx]) : 32'hFFFF_FFFF;
  endfunction

  task automatic put_cyc(input logic d, input logic e);
    if (ncyc >= MAXC) begin
      $display("FAIL stimulus_overflow cycles=%0d limit=%0d", ncyc, MAXC);
      $fatal(1);
    end
    s_din[ncyc] = d;
    s_en[ncyc]  = e;
    ncyc++;
  endtask

  // mode 0: every cycle enabled; 1: enabled/disabled alternate; 2: random gaps.
  task automatic add_bit(input logic b);
    if (en_mode == 2)
      for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) put_cyc(1'($urandom), 1'b0);
    put_cyc(b, 1'b1);
    last_bit_cyc = ncyc - 1;
    if (en_mode == 1) put_cyc(1'($urandom), 1'b0);
  endtask

  task automatic add_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) add_bit(v[k]);
  endtask

  task automatic build(input logic [23:0] len, input logic [3:0] trl, input logic [255:0] dat,
                       input int badp, input int tail);
    logic p;
    int   fidx;
    ncyc = 0;
    p    = 1'b0;
    fidx = 0;
    add_bits(32'hFF, 8);
    add_bits(32'hF2, 8);
    add_bits(32'(len), 24);
    add_bits(32'(trl), 4);
    if (trl == 4'hF) begin
      for (int k = 0; k < int'(len); k++) begin
        add_bit(dat[255-k]);
        p = p ^ dat[255-k];
        if ((k % FW) == FW - 1 || k == int'(len) - 1) begin
`ifdef XC20XX_CFG_PARITY_EN
          add_bit((fidx == badp) ? ~p : p);
`endif
          p = 1'b0;
          fidx++;
        end
      end
    end
    repeat (tail) put_cyc(1'($urandom), 1'($urandom));
  endtask

  // Parses the enabled-bit stream as a whole and derives each output's timeline.
  task automatic run_model();
    logic          bv[$];
    int            bc[$];
    logic [7:0]    sr;
    logic [23:0]   len;
    logic [FW-1:0] d;
    logic          p;
    int            i, rem, n, lastc, err_c, end_c, addr, j;
    bit            ok;
    int            em_c[$];
    logic [FW-1:0] em_d[$];
    logic [AW-1:0] em_a[$];
    logic [FW-1:0] cur_d;
    logic [AW-1:0] cur_a;

    for (int c = 0; c < ncyc; c++)
      if (s_en[c]) begin
        bv.push_back(s_din[c]);
        bc.push_back(c);
      end
    err_c = NEVER; end_c = NEVER; ok = 1'b1; i = 0; sr = '0; len = '0; lastc = 0; addr = 0;
    while (i < bv.size() && sr != 8'hF2) begin
      sr = {sr[6:0], bv[i]};
      i++;
    end
    if (sr != 8'hF2 || i + 28 > bv.size()) ok = 1'b0;
    if (ok) begin
      for (int k = 0; k < 24; k++) begin
        len = {len[22:0], bv[i]};
        i++;
      end
      for (int k = 0; k < 4 && ok; k++) begin
        if (!bv[i]) begin
          err_c = bc[i];
          ok = 1'b0;
        end
        lastc = bc[i];
        i++;
      end
    end
    rem = ok ? int'(len) : 0;
    while (ok && rem > 0) begin
      n = (rem < FW) ? rem : FW;
      d = '0;
      p = 1'b0;
      if (i + n > bv.size()) ok = 1'b0;
      else begin
        for (int k = 0; k < n; k++) begin
          d[FW-1-k] = bv[i];
          p = p ^ bv[i];
          lastc = bc[i];
          i++;
        end
`ifdef XC20XX_CFG_PARITY_EN
        if (i >= bv.size()) ok = 1'b0;
        else begin
          if (bv[i] != p) begin
            err_c = bc[i];
            ok = 1'b0;
          end
          lastc = bc[i];
          i++;
        end
`endif
        if (ok) begin
          em_c.push_back(lastc);
          em_d.push_back(d);
          em_a.push_back(AW'(addr));
          addr++;
          rem -= n;
        end
      end
    end
    if (ok) end_c = lastc;

    j = 0; cur_d = '0; cur_a = '0;
    for (int c = 0; c < ncyc; c++) begin
      e_vld[c] = 1'b0;
      if (j < em_c.size() && em_c[j] == c) begin
        e_vld[c] = 1'b1;
        cur_d = em_d[j];
        cur_a = em_a[j];
        j++;
      end
      e_data[c] = cur_d;
      e_addr[c] = cur_a;
      e_err[c]  = (c >= err_c);
      e_done[c] = (end_c != NEVER) && (c >= end_c + SC);
      e_gr[c]   = !((end_c != NEVER) && (c >= end_c + SC + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge K);
    RN = 1'b0; DIN = 1'b0; DIN_EN = 1'b0;
    #1;
    chk("rst_vld",  0, 32'(FRAME_VLD),  32'd0);
    chk("rst_data", 0, 32'(FRAME_DATA), 32'd0);
    chk("rst_addr", 0, 32'(FRAME_ADDR), 32'd0);
    chk("rst_gr",   0, 32'(GR),         32'd1);
    chk("rst_done", 0, 32'(DONE),       32'd0);
    chk("rst_err",  0, 32'(ERR),        32'd0);
    @(negedge K);
    RN = 1'b1;
    obs_d.delete();
    obs_a.delete();
    obs_done_c = -1;
    obs_err_c  = -1;
  endtask

  // Drive on the falling edge, compare 1ns after the rising edge.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      DIN    = s_din[c];
      DIN_EN = s_en[c];
      @(posedge K);
      #1;
      chk("vld",  c, 32'(FRAME_VLD),  32'(e_vld[c]));
      chk("data", c, 32'(FRAME_DATA), 32'(e_data[c]));
      chk("addr", c, 32'(FRAME_ADDR), 32'(e_addr[c]));
      chk("gr",   c, 32'(GR),         32'(e_gr[c]));
      chk("done", c, 32'(DONE),       32'(e_done[c]));
      chk("err",  c, 32'(ERR),        32'(e_err[c]));
      if (FRAME_VLD) begin
        obs_d.push_back(FRAME_DATA);
        obs_a.push_back(FRAME_ADDR);
      end
      if (DONE && obs_done_c < 0) obs_done_c = c;
      if (ERR && obs_err_c < 0) obs_err_c = c;
      @(negedge K);
    end
  endtask

  task automatic scenario(input int mode, input logic [23:0] len, input logic [3:0] trl,
                          input logic [255:0] dat, input int badp, input int tail);
    en_mode = mode;
    build(len, trl, dat, badp, tail);
    run_model();
    do_reset();
    run_cycles(ncyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] rdat;
    logic [3:0]   rtrl;
    int           rbad;

    // Two full frames.
    scenario(0, 24'd32, 4'hF, {16'hA5A5, 16'h3C3C, 224'd0}, -1, 12);
    chk("s1_nframes", 0, 32'(obs_d.size()), 32'd2);
    chk("s1_d0", 0, obs_dat(0), 32'h0000_A5A5);
    chk("s1_a0", 0, obs_adr(0), 32'd0);
    chk("s1_d1", 0, obs_dat(1), 32'h0000_3C3C);
    chk("s1_a1", 0, obs_adr(1), 32'd1);
    chk("s1_done_lat", 0, 32'(obs_done_c), 32'(last_bit_cyc + 4));
    chk("s1_no_err", 0, 32'(obs_err_c), 32'hFFFF_FFFF);

    // Partial final frame, left-aligned.
    scenario(0, 24'd20, 4'hF, {16'hA5A5, 4'b1011, 236'd0}, -1, 12);
    chk("s2_d1", 0, obs_dat(1), 32'h0000_B000);
    chk("s2_a1", 0, obs_adr(1), 32'd1);

    // Zero length: straight to startup.
    scenario(0, 24'd0, 4'hF, 256'd0, -1, 12);
    chk("s3_nframes", 0, 32'(obs_d.size()), 32'd0);
    chk("s3_done_lat", 0, 32'(obs_done_c), 32'(last_bit_cyc + 4));

    // Bad trailer: error on the third trailer bit (cycle 42), then held for 50+ cycles.
    scenario(0, 24'd32, 4'b1101, {16'hA5A5, 16'h3C3C, 224'd0}, -1, 55);
    chk("s4_err_cyc", 0, 32'(obs_err_c), 32'd42);
    chk("s4_no_done", 0, 32'(obs_done_c), 32'hFFFF_FFFF);

    // Abort mid second frame, then a fresh load.
    en_mode = 0;
    build(24'd32, 4'hF, {16'hA5A5, 16'h3C3C, 224'd0}, -1, 12);
    run_model();
    do_reset();
    run_cycles(68);
    chk("s5_pre_abort_vld", 0, 32'(obs_d.size()), 32'd1);
    scenario(0, 24'd32, 4'hF, {16'hA5A5, 16'h3C3C, 224'd0}, -1, 12);
    chk("s5_a0", 0, obs_adr(0), 32'd0);
    chk("s5_a1", 0, obs_adr(1), 32'd1);

    // DIN_EN toggling every cycle.
    scenario(1, 24'd32, 4'hF, {16'hA5A5, 16'h3C3C, 224'd0}, -1, 12);
    chk("s6_nframes", 0, 32'(obs_d.size()), 32'd2);
    chk("s6_d0", 0, obs_dat(0), 32'h0000_A5A5);
    chk("s6_d1", 0, obs_dat(1), 32'h0000_3C3C);
    chk("s6_a1", 0, obs_adr(1), 32'd1);

`ifdef XC20XX_CFG_PARITY_EN
    // Wrong parity after the first frame.
    scenario(0, 24'd32, 4'hF, {16'hA5A5, 16'h3C3C, 224'd0}, 0, 20);
    chk("s7_nframes", 0, 32'(obs_d.size()), 32'd0);
    chk("s7_err", 0, 32'(obs_err_c >= 0), 32'd1);
`endif

    // Random lengths, data, gaps and occasional bad trailers/parity.
    for (int r = 0; r < 10; r++) begin
      for (int w = 0; w < 8; w++) rdat[w*32 +: 32] = $urandom;
      rtrl = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      rbad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      scenario(2, 24'($urandom_range(1, 120)), rtrl, rdat, rbad, 16);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/xc20xx_cfg_loader.md
# xc20xx_cfg_loader

Serial configuration loader and startup sequencer for the XC20xx fabric model. Deserialises the configuration bitstream into fixed-width frames for the configuration memory. Holds the global reset net GR, which drives the R input of every XC20XX_DFFSR, asserted until configuration completes. Releases GR through a fixed startup sequence.

## Interface
- FRAME_W, 16: configuration frame width in bits (≥2).
- ADDR_W, 8: frame address width.
- STARTUP_CYC, 4: K edges spent in STARTUP before DONE rises (≥1).

- K  in  1  clock, rising-edge.
- RN  in  1  reset; one clock, reset asynchronous active-low.
- DIN  in  1  serial configuration data, MSB-first.
- DIN_EN  in  1  DIN is sampled only on K edges where DIN_EN=1.
- FRAME_DATA  out  FRAME_W  completed frame; first received bit at MSB.
- FRAME_ADDR  out  ADDR_W  address of FRAME_DATA.
- FRAME_VLD  out  1  one-cycle strobe qualifying FRAME_DATA/FRAME_ADDR.
- GR  out  1  global reset to the fabric flip-flops, active-high.
- DONE  out  1  configuration complete.
- ERR  out  1  sticky format error.

## Operation
- States: HUNT, LEN, TRAIL, DATA, STARTUP, RUN, ERROR. All transitions occur on a K edge.
- Bit-consuming states (HUNT, LEN, TRAIL, DATA) advance only on edges with DIN_EN=1. STARTUP counts every edge.
- HUNT: an 8-bit shift register (reset 0) takes DIN. When the updated value equals 8'hF2 (1111_0010), go to LEN.
- LEN: shift 24 bits MSB-first into a length counter L, giving the data-bit count. After the 24th bit, go to TRAIL.
- TRAIL: expect 4 bits of 1.
  - Any 0 → ERROR on that edge.
  - After the 4th 1: go to DATA if L≠0; otherwise go to STARTUP with no frames emitted.
- DATA: each bit shifts into the frame register and L decrements.
  - A frame completes when FRAME_W bits have been collected or L reaches 0.
  - A partial final frame is left-aligned with the unused LSBs set to zero.
  - On completion, FRAME_DATA/FRAME_ADDR are loaded and FRAME_VLD=1 for one cycle.
  - FRAME_ADDR starts at 0, increments after each frame, and wraps modulo 2^ADDR_W without error.
  - When the last frame completes, go to STARTUP.
- STARTUP: load a counter with STARTUP_CYC and decrement it every edge. At 0, go to RUN; DONE=1 on the same edge.
- RUN: GR=0 on the first edge in RUN. RUN is terminal.
- ERROR: terminal. ERR=1, GR=1, DONE=0, no further frames; only RN exits.
- GR=1 in every state except RUN.

## Timing
- Reset values: FRAME_DATA=0, FRAME_ADDR=0, FRAME_VLD=0, GR=1, DONE=0, ERR=0, state HUNT, all counters 0. Outputs change immediately on RN low.
- RN low mid-operation aborts the load. The next load restarts from HUNT with FRAME_ADDR=0.
- All outputs are registered.
- FRAME_VLD is high in the cycle after the K edge that sampled the frame's last bit.
- Back-to-back frames produce FRAME_VLD pulses at least FRAME_W cycles apart.
- DIN_EN=0 holds FRAME_VLD low after its single pulse and freezes all bit-consuming state.
- Last data bit to DONE: STARTUP_CYC edges. DONE to GR falling: 1 edge.

## Configuration
- XC20XX_CFG_PARITY_EN defined:
  - After the last bit of every frame (including a partial final frame), one even-parity bit over the frame's received data bits follows. Parity bits are not counted in L.
  - FRAME_VLD asserts only after a correct parity bit.
  - A mismatch → ERROR on the parity-bit edge, and that frame is not emitted.
- Undefined: no parity bits; behaviour as above.

## Test plan
- Stream FF F2, L=24'd32, 1111, data A5A5 3C3C with DIN_EN=1: FRAME_VLD twice (A5A5@0, 3C3C@1). DONE 4 edges after the last bit. GR falls 1 edge later. ERR=0.
- L=24'd20, data A5A5 then 1011: second frame FRAME_DATA=16'hB000 at FRAME_ADDR=1, then startup as above.
- L=24'd0, trailer 1111: no FRAME_VLD. DONE 4 edges after the 4th trailer bit, GR=0 one edge later.
- Trailer 1101: ERR=1 on the 3rd trailer bit. GR stays 1, DONE stays 0 for 50 further cycles.
- RN pulsed low during the second frame of the first scenario: all outputs return to reset values. A fresh full stream then yields FRAME_ADDR 0 and 1 again.
- With the first scenario's stream, DIN_EN toggled 1/0 every cycle: identical frames and addresses, each FRAME_VLD still one cycle wide. Under XC20XX_CFG_PARITY_EN, a wrong parity after A5A5 → ERR=1 and no FRAME_VLD.
